debug_break_ctrl: RTL and testbench

//  Breakpoint/debug sequencer for the 5-stage pipeline. Holds NUM_BP programmable
//  PC breakpoints and compares them against the instruction currently in ID.

---
 rtl/debug_break_ctrl.sv | 178 +++++++++++++++++
 tb/tb_debug_break_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_break_ctrl.sv
// Breakpoint/debug sequencer: PC breakpoints checked in ID, halt/continue/step control.
// Optional feature macro: DBG_SINGLE_STEP_EN builds the STEP state and step button path.
module debug_break_ctrl #(
  parameter int unsigned NUM_BP  = 4,
  parameter int unsigned SYNC_ST = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bp_wr_en,
  input  logic [2:0]  bp_wr_idx,
  input  logic [31:0] bp_wr_addr,
  input  logic        bp_wr_valid,
  input  logic [31:0] id_pc,
  input  logic        id_valid,
  input  logic        continue_btn,
  input  logic        step_btn,
  input  logic        halt_req,
  output logic        stall_dbg,
  output logic        halted,
  output logic [2:0]  hit_idx,
  output logic [15:0] hit_count
);

`ifdef DBG_SINGLE_STEP_EN
  typedef enum logic [1:0] {RUN, HALT, RESUME, STEP} state_t;
`else
  typedef enum logic [1:0] {RUN, HALT, RESUME} state_t;
`endif

  state_t       state;
  logic [31:0]  halt_pc;
  logic         slot_en   [NUM_BP];
  logic [29:0]  slot_addr [NUM_BP];

  logic         bp_any;
  logic [2:0]   bp_idx;
  logic         new_instr;
  logic         run_like;
  logic         bp_hit;

  logic [SYNC_ST-1:0] cont_sync;
  logic               cont_prev;
  logic               cont_ev;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^bp_wr_addr[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_BP; i++) begin
        slot_en[i]   <= 1'b0;
        slot_addr[i] <= '0;
      end
    end else if (bp_wr_en) begin
      for (int unsigned i = 0; i < NUM_BP; i++) begin
        if (bp_wr_idx == 3'(i)) begin
          slot_en[i]   <= bp_wr_valid;
          slot_addr[i] <= bp_wr_addr[31:2];
        end
      end
    end
  end

  // Scan from the top so the lowest matching slot is the one left standing.
  always_comb begin
    bp_any = 1'b0;
    bp_idx = '0;
    for (int unsigned i = NUM_BP; i > 0; i--) begin
      if (slot_en[i-1] && (slot_addr[i-1] == id_pc[31:2])) begin
        bp_any = 1'b1;
        bp_idx = 3'(i-1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cont_sync <= '0;
      cont_prev <= 1'b0;
    end else begin
      cont_sync <= {cont_sync[SYNC_ST-2:0], continue_btn};
      cont_prev <= cont_sync[SYNC_ST-1];
    end
  end
  assign cont_ev = cont_sync[SYNC_ST-1] & ~cont_prev;

`ifdef DBG_SINGLE_STEP_EN
  logic [SYNC_ST-1:0] step_sync;
  logic               step_prev;
  logic               step_ev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_sync <= '0;
      step_prev <= 1'b0;
    end else begin
      step_sync <= {step_sync[SYNC_ST-2:0], step_btn};
      step_prev <= step_sync[SYNC_ST-1];
    end
  end
  assign step_ev = step_sync[SYNC_ST-1] & ~step_prev;
`else
  logic unused_step;
  assign unused_step = step_btn;
`endif

  // RESUME's release cycle behaves exactly like RUN, so a breakpoint on the
  // next instruction is still caught with zero latency.
  assign new_instr = id_valid && (id_pc != halt_pc);
  assign run_like  = (state == RUN) || ((state == RESUME) && new_instr);
  assign bp_hit    = run_like && id_valid && bp_any;

  always_comb begin
    stall_dbg = 1'b0;
    case (state)
      RUN, RESUME: stall_dbg = bp_hit;
      HALT:        stall_dbg = 1'b1;
`ifdef DBG_SINGLE_STEP_EN
      STEP:        stall_dbg = new_instr;
`endif
      default:     stall_dbg = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      halted    <= 1'b0;
      halt_pc   <= '0;
      hit_idx   <= '0;
      hit_count <= '0;
    end else begin
      case (state)
        RUN, RESUME: begin
          if (bp_hit) begin
            state   <= HALT;
            halted  <= 1'b1;
            hit_idx <= bp_idx;
            if (hit_count != 16'hFFFF)
              hit_count <= hit_count + 16'd1;
          end else if (run_like && halt_req) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (run_like) begin
            state <= RUN;
          end
        end
        HALT: begin
          // ID is frozen while halted, so tracking id_pc here holds the entry PC.
          halt_pc <= id_pc;
`ifdef DBG_SINGLE_STEP_EN
          if (step_ev) begin
            state  <= STEP;
            halted <= 1'b0;
          end else
`endif
          if (cont_ev) begin
            state  <= RESUME;
            halted <= 1'b0;
          end
        end
`ifdef DBG_SINGLE_STEP_EN
        STEP: begin
          if (new_instr) begin
            state  <= HALT;
            halted <= 1'b1;
          end
        end
`endif
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_break_ctrl.sv
// Self-checking bench for debug_break_ctrl: directed scenarios plus a randomized
// breakpoint/program walk checked against a program-order reference model.
module tb_debug_break_ctrl;
  localparam int unsigned NUM_BP  = 4;
  localparam int unsigned SYNC_ST = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bp_wr_en = 1'b0;
  logic [2:0]  bp_wr_idx = '0;
  logic [31:0] bp_wr_addr = '0;
  logic        bp_wr_valid = 1'b0;
  logic [31:0] id_pc = '0;
  logic        id_valid = 1'b0;
  logic        continue_btn = 1'b0;
  logic        step_btn = 1'b0;
  logic        halt_req = 1'b0;
  logic        stall_dbg;
  logic        halted;
  logic [2:0]  hit_idx;
  logic [15:0] hit_count;

  debug_break_ctrl #(.NUM_BP(NUM_BP), .SYNC_ST(SYNC_ST)) dut (
    .clk(clk), .rst_n(rst_n),
    .bp_wr_en(bp_wr_en), .bp_wr_idx(bp_wr_idx), .bp_wr_addr(bp_wr_addr), .bp_wr_valid(bp_wr_valid),
    .id_pc(id_pc), .id_valid(id_valid),
    .continue_btn(continue_btn), .step_btn(step_btn), .halt_req(halt_req),
    .stall_dbg(stall_dbg), .halted(halted), .hit_idx(hit_idx), .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] ex_log[$];
  bit          ld_hold = 1'b0;
  bit          last_stall = 1'b0;
  logic [31:0] br_src = 32'hFFFF_FFFC;
  logic [31:0] br_dst = '0;

  logic [31:0] m_addr [NUM_BP];
  bit          m_en   [NUM_BP];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int ex_count(input logic [31:0] pc);
    int c = 0;
    foreach (ex_log[i]) if (ex_log[i] == pc) c++;
    return c;
  endfunction

  // One clock of the pipeline: ID advances unless stalled or held by a load-use.
  task automatic cyc();
    bit s;
    @(negedge clk);
    s = stall_dbg;
    last_stall = s;
    if (id_valid && !s && !ld_hold) ex_log.push_back(id_pc);
    @(posedge clk);
    #1;
    if (!s && !ld_hold) id_pc = (id_pc == br_src) ? br_dst : id_pc + 32'd4;
  endtask

  task automatic do_reset(input logic [31:0] start);
    rst_n = 1'b0;
    bp_wr_en = 1'b0; halt_req = 1'b0; continue_btn = 1'b0; step_btn = 1'b0;
    ld_hold = 1'b0; id_valid = 1'b1; id_pc = start; br_src = 32'hFFFF_FFFC;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    ex_log.delete();
  endtask

  task automatic write_bp(input logic [2:0] idx, input logic [31:0] addr, input bit v);
    bp_wr_en = 1'b1; bp_wr_idx = idx; bp_wr_addr = addr; bp_wr_valid = v;
    cyc();
    bp_wr_en = 1'b0;
  endtask

  task automatic wait_halt(input int max_cyc, input bit rnd_hold, input string tag);
    for (int i = 0; i < max_cyc && !halted; i++) begin
      if (rnd_hold) ld_hold = ($urandom_range(0, 3) == 0);
      cyc();
    end
    ld_hold = 1'b0;
    check(tag, {31'd0, halted}, 32'd1);
  endtask

  // Pulse buttons for one clock; count stalled cycles until the stall drops.
  task automatic press(input bit c, input bit s, input string tag);
    int n = 0;
    continue_btn = c; step_btn = s;
    for (int k = 0; k < 12; k++) begin
      cyc();
      if (k == 0) begin continue_btn = 1'b0; step_btn = 1'b0; end
      if (last_stall) n++;
      else break;
    end
    check(tag, 32'(n), 32'(SYNC_ST + 1));
  endtask

  function automatic int m_lowest(input logic [31:0] pc);
    for (int i = 0; i < int'(NUM_BP); i++)
      if (m_en[i] && (m_addr[i][31:2] == pc[31:2])) return i;
    return -1;
  endfunction

  function automatic logic [31:0] m_next(input logic [31:0] pc);
    return (pc == 32'h1FC) ? 32'h100 : pc + 32'd4;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] p;
    logic [31:0] held;
    int          exp_idx;
    int          exp_cnt;

    // Reset state
    do_reset(32'h20);
    check("rst_stall", {31'd0, stall_dbg}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_hit_idx", {29'd0, hit_idx}, 32'd0);
    check("rst_hit_count", {16'd0, hit_count}, 32'd0);

    // Breakpoint at 0x30 halts before it reaches EX, then continue
    write_bp(3'd0, 32'h30, 1'b1);
    wait_halt(40, 1'b0, "t1_halt");
    check("t1_halt_pc", id_pc, 32'h30);
    check("t1_stall", {31'd0, stall_dbg}, 32'd1);
    check("t1_hit_idx", {29'd0, hit_idx}, 32'd0);
    check("t1_hit_count", {16'd0, hit_count}, 32'd1);
    check("t1_ex_0x30", 32'(ex_count(32'h30)), 32'd0);
    check("t1_ex_0x2c", 32'(ex_count(32'h2C)), 32'd1);
    press(1'b1, 1'b0, "t2_cont_lat");
    repeat (8) cyc();
    check("t2_ex_0x30", 32'(ex_count(32'h30)), 32'd1);
    check("t2_halted", {31'd0, halted}, 32'd0);
    check("t2_stall", {31'd0, stall_dbg}, 32'd0);
    check("t2_hit_count", {16'd0, hit_count}, 32'd1);

    // Lowest slot wins; ignored index; disable while halted
    do_reset(32'h20);
    write_bp(3'd1, 32'h40, 1'b1);
    write_bp(3'd3, 32'h42, 1'b1);
    write_bp(3'd5, 32'h38, 1'b1);
    wait_halt(40, 1'b0, "t4_halt");
    check("t4_halt_pc", id_pc, 32'h40);
    check("t4_hit_idx", {29'd0, hit_idx}, 32'd1);
    check("t4_hit_count", {16'd0, hit_count}, 32'd1);
    check("t4_ex_0x38", 32'(ex_count(32'h38)), 32'd1);
    write_bp(3'd1, 32'h40, 1'b0);
    br_src = 32'h50; br_dst = 32'h3C;
    press(1'b1, 1'b0, "t4_cont_lat");
    wait_halt(60, 1'b0, "t4_rehalt");
    check("t4_rehalt_pc", id_pc, 32'h40);
    check("t4_rehit_idx", {29'd0, hit_idx}, 32'd3);
    check("t4_rehit_count", {16'd0, hit_count}, 32'd2);
    check("t4_ex_0x40", 32'(ex_count(32'h40)), 32'd1);

    // Single step
    do_reset(32'h20);
    write_bp(3'd0, 32'h30, 1'b1);
    br_src = 32'h30; br_dst = 32'h80;
    wait_halt(40, 1'b0, "t3_halt");
`ifdef DBG_SINGLE_STEP_EN
    press(1'b0, 1'b1, "t3_step_lat");
    wait_halt(20, 1'b0, "t3_step_halt");
    check("t3_step_pc", id_pc, 32'h80);
    check("t3_step_stall", {31'd0, stall_dbg}, 32'd1);
    check("t3_ex_0x30", 32'(ex_count(32'h30)), 32'd1);
    check("t3_hit_count", {16'd0, hit_count}, 32'd1);
    press(1'b0, 1'b1, "t3_step2_lat");
    wait_halt(20, 1'b0, "t3_step2_halt");
    check("t3_step2_pc", id_pc, 32'h84);
    check("t3_ex_0x80", 32'(ex_count(32'h80)), 32'd1);
    press(1'b1, 1'b1, "t3_both_lat");
    wait_halt(20, 1'b0, "t3_both_halt");
    check("t3_both_pc", id_pc, 32'h88);
    check("t3_both_count", {16'd0, hit_count}, 32'd1);
`else
    step_btn = 1'b1;
    cyc();
    step_btn = 1'b0;
    repeat (8) cyc();
    check("t3_nostep_halted", {31'd0, halted}, 32'd1);
    check("t3_nostep_pc", id_pc, 32'h30);
    check("t3_nostep_ex", 32'(ex_count(32'h30)), 32'd0);
`endif

    // Continue under a load-use hold, halt_req, then async reset while halted
    do_reset(32'h20);
    write_bp(3'd0, 32'h30, 1'b1);
    wait_halt(40, 1'b0, "t5_halt");
    ld_hold = 1'b1;
    press(1'b1, 1'b0, "t5_cont_lat");
    repeat (3) cyc();
    check("t5_resume_stall", {31'd0, stall_dbg}, 32'd0);
    check("t5_resume_halted", {31'd0, halted}, 32'd0);
    ld_hold = 1'b0;
    repeat (6) cyc();
    check("t5_ex_0x30", 32'(ex_count(32'h30)), 32'd1);
    check("t5_no_rehalt", {31'd0, halted}, 32'd0);
    halt_req = 1'b1;
    cyc();
    halt_req = 1'b0;
    check("t5_req_halted", {31'd0, halted}, 32'd1);
    check("t5_req_count", {16'd0, hit_count}, 32'd1);
    held = id_pc;
    repeat (3) cyc();
    check("t5_req_hold", id_pc, held);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_stall", {31'd0, stall_dbg}, 32'd0);
    check("t5_rst_halted", {31'd0, halted}, 32'd0);
    check("t5_rst_count", {16'd0, hit_count}, 32'd0);

    // Random breakpoints over a looping program; tail covers count saturation
    do_reset(32'h100);
    id_valid = 1'b0;
    ld_hold = 1'b1;
    for (int i = 0; i < int'(NUM_BP); i++) begin
      m_addr[i] = 32'h100 + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(0, 3));
      m_en[i]   = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      write_bp(3'(i), m_addr[i], m_en[i]);
    end
    ld_hold = 1'b0;
    id_valid = 1'b1;
    br_src = 32'h1FC; br_dst = 32'h100;
    ex_log.delete();
    p = 32'h100;
    for (int it = 0; it < 8; it++) begin
      while (m_lowest(p) < 0) p = m_next(p);
      exp_idx = m_lowest(p);
      exp_cnt = (it >= 6) ? 32'hFFFF : it + 1;
      if (it == 6) begin
        force dut.hit_count = 16'hFFFE;
        #1;
        release dut.hit_count;
      end
      if (it > 0) press(1'b1, 1'b0, "rnd_cont_lat");
      wait_halt(300, 1'b1, "rnd_halt");
      check("rnd_halt_pc", id_pc, p);
      check("rnd_hit_idx", {29'd0, hit_idx}, 32'(exp_idx));
      check("rnd_hit_count", {16'd0, hit_count}, 32'(exp_cnt));
      p = m_next(p);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
